// File: rtl/tdc_pkg.sv
// Shared TDC merge definitions: fine/coarse code widths, FSM state encoding
// and the output word width helpers.
package tdc_pkg;

  localparam int unsigned NUM_DECODE  = 8;
  localparam int unsigned COUNTER_DIG = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SETTLE,
    S_READOUT,
    S_DONE
  } state_e;

  // Channel-id field width; never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

  // Output word: {ch_id, timeout_flag, coarse, start_code, stop_code}.
  function automatic int unsigned dig_out_mc(input int unsigned nch);
    return ch_w(nch) + 1 + COUNTER_DIG + 2 * NUM_DECODE;
  endfunction

endpackage

// File: rtl/tdc_merge_mc_if.sv
// Valid/ready output stream of the TDC merge block.
//   out       : data word (W bits)
//   out_valid : word valid
//   out_ready : downstream accept
interface tdc_merge_mc_if #(
  parameter int unsigned W = 29
);
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;

  modport master (output out, output out_valid, input out_ready);
  modport slave  (input out, input out_valid, output out_ready);
endinterface

// File: rtl/tdc_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge detector.
//   clk, rst : clock, asynchronous active-high reset
//   din      : asynchronous level input
//   pulse    : one-cycle pulse, usable by downstream logic on the third
//              clk edge after din is first sampled high
module tdc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  // sh[1:0] synchronise, sh[2] holds the previous synchronised level.
  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh    <= '0;
      pulse <= 1'b0;
    end else begin
      sh    <= {sh[1:0], din};
      pulse <= sh[1] & ~sh[2];
    end
  end

endmodule

// File: rtl/tdc_merge_mc.sv
// Multi-channel TDC merge: captures a start fine code and per-channel stop
// fine/coarse codes, waits a settle period, then streams one word per hit
// channel in ascending channel order.
// Optional feature macro: TDC_TIMEOUT_EN (ARMED timeout after TMO_CYC cycles).
//   clk, irst      : clock, asynchronous active-high reset
//   in_store_start : async start strobe
//   in_store_stop  : async per-channel stop strobes
//   ch_en          : channel enable mask, sampled on start in IDLE
//   StartEdge      : start fine code
//   FallEdge       : stop fine codes, channel k at [k*NUM_DECODE +: NUM_DECODE]
//   Coarse         : coarse counter
//   o              : output stream (out, out_valid, out_ready)
//   busy           : high outside IDLE
//   done           : one-cycle end-of-measurement pulse
module tdc_merge_mc
  import tdc_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      irst,
  input  logic                      in_store_start,
  input  logic [NCH-1:0]            in_store_stop,
  input  logic [NCH-1:0]            ch_en,
  input  logic [NUM_DECODE-1:0]     StartEdge,
  input  logic [NCH*NUM_DECODE-1:0] FallEdge,
  input  logic [COUNTER_DIG-1:0]    Coarse,
  tdc_merge_mc_if.master            o,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned CH_W  = ch_w(NCH);
  localparam int unsigned DW    = dig_out_mc(NCH);
  localparam int unsigned SET_W = 8;

  // Reset asserts immediately, releases two clk edges after irst falls.
  logic [1:0] rst_q;
  logic       rst;

  always_ff @(posedge clk or posedge irst) begin
    if (irst) rst_q <= 2'b11;
    else      rst_q <= {rst_q[0], 1'b0};
  end

  assign rst = rst_q[1];

  logic           start_pulse;
  logic [NCH-1:0] stop_pulse;

  tdc_edge_sync u_start_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (in_store_start),
    .pulse (start_pulse)
  );

  for (genvar k = 0; k < NCH; k++) begin : g_stop_sync
    tdc_edge_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (in_store_stop[k]),
      .pulse (stop_pulse[k])
    );
  end

  state_e                  state;
  logic [NCH-1:0]          mask;
  logic [NCH-1:0]          hit;
  logic [NCH-1:0]          pend;
  logic [NUM_DECODE-1:0]   start_code;
  logic [NUM_DECODE-1:0]   stop_code [NCH];
  logic [COUNTER_DIG-1:0]  coarse_q  [NCH];
  logic [SET_W-1:0]        settle_cnt;
  logic [DW-1:0]           out_q;
  logic                    out_valid_q;
  logic                    tmo_flag;

`ifdef TDC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_end_c;
  assign tmo_end_c = (tmo_cnt == TMO_W'(TMO_CYC - 1));
`else
  // Without the timeout feature the flag is a tied-off zero field.
  assign tmo_flag = 1'b0 & (TMO_CYC == 0);
`endif

  logic [NCH-1:0]  new_hit_c;
  logic [NCH-1:0]  hit_nxt_c;
  logic [NCH-1:0]  pick_c;
  logic [CH_W-1:0] sel_c;
  logic [NCH-1:0]  sel_oh_c;
  logic [DW-1:0]   word_c;

  assign new_hit_c = stop_pulse & mask & ~hit;
  assign hit_nxt_c = hit | new_hit_c;

  // First word is picked from hit while leaving SETTLE, later ones from pend.
  assign pick_c = (state == S_SETTLE) ? hit : pend;

  // Lowest-index pending channel.
  always_comb begin
    sel_c = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pick_c[i]) sel_c = CH_W'(i);
    end
  end

  assign sel_oh_c = NCH'(1) << sel_c;
  assign word_c   = {sel_c, tmo_flag, coarse_q[sel_c], start_code, stop_code[sel_c]};

  // Measurement FSM with registered stream, busy and done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mask        <= '0;
      hit         <= '0;
      pend        <= '0;
      start_code  <= '0;
      settle_cnt  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        stop_code[k] <= '0;
        coarse_q[k]  <= '0;
      end
`ifdef TDC_TIMEOUT_EN
      tmo_cnt     <= '0;
      tmo_flag    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_pulse && (|ch_en)) begin
            mask       <= ch_en;
            start_code <= StartEdge;
            busy       <= 1'b1;
            state      <= S_ARMED;
`ifdef TDC_TIMEOUT_EN
            tmo_cnt    <= '0;
            tmo_flag   <= 1'b0;
`endif
          end
        end

        S_ARMED: begin
          for (int k = 0; k < NCH; k++) begin
            if (new_hit_c[k]) begin
              stop_code[k] <= FallEdge[k*NUM_DECODE +: NUM_DECODE];
              coarse_q[k]  <= Coarse;
            end
          end
          hit        <= hit_nxt_c;
          settle_cnt <= '0;
          if (hit_nxt_c == mask) begin
            state <= S_SETTLE;
          end
`ifdef TDC_TIMEOUT_EN
          else if (tmo_end_c) begin
            tmo_flag <= 1'b1;
            if (hit_nxt_c == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SETTLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end

        S_SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE - 1)) begin
            out_q       <= word_c;
            out_valid_q <= 1'b1;
            pend        <= hit & ~sel_oh_c;
            state       <= S_READOUT;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end

        S_READOUT: begin
          // Next word is loaded on the transfer edge so there is no bubble.
          if (out_valid_q && o.out_ready) begin
            if (|pend) begin
              out_q <= word_c;
              pend  <= pend & ~sel_oh_c;
            end else begin
              out_valid_q <= 1'b0;
              done        <= 1'b1;
              state       <= S_DONE;
            end
          end
        end

        S_DONE: begin
          hit   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign o.out       = out_q;
  assign o.out_valid = out_valid_q;

endmodule

// File: tb/tb_tdc_merge_mc.sv
// Directed self-checking bench for tdc_merge_mc (NCH=4, SETTLE=4).
// Honours TDC_TIMEOUT_EN to run the timeout scenarios with TMO_CYC=16.
module tb_tdc_merge_mc;
  import tdc_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = dig_out_mc(NCH);
`ifdef TDC_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 1024;
`endif

  logic                      clk = 1'b0;
  logic                      irst;
  logic                      in_store_start;
  logic [NCH-1:0]            in_store_stop;
  logic [NCH-1:0]            ch_en;
  logic [NUM_DECODE-1:0]     StartEdge;
  logic [NCH*NUM_DECODE-1:0] FallEdge;
  logic [COUNTER_DIG-1:0]    Coarse;
  logic                      busy;
  logic                      done;

  tdc_merge_mc_if #(.W(DW)) bus ();

  tdc_merge_mc #(.NCH(NCH), .SETTLE(4), .TMO_CYC(TMO)) dut (
    .clk            (clk),
    .irst           (irst),
    .in_store_start (in_store_start),
    .in_store_stop  (in_store_stop),
    .ch_en          (ch_en),
    .StartEdge      (StartEdge),
    .FallEdge       (FallEdge),
    .Coarse         (Coarse),
    .o              (bus),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] mk(input int ch, input logic tf,
                                        input logic [9:0] crs, input logic [7:0] st,
                                        input logic [7:0] sp);
    logic [1:0] id;
    id = 2'(ch);
    return {id, tf, crs, st, sp};
  endfunction

  // Stream monitor, sampled mid-cycle.
  logic [DW-1:0] got[$];
  int            got_t[$];
  int            cyc = 0;
  int            done_cnt = 0;
  int            viol = 0;
  logic          prev_done = 1'b0;
  logic          busy_at_done = 1'b0;
  logic          busy_after = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (bus.out_valid && bus.out_ready) begin
      got.push_back(bus.out);
      got_t.push_back(cyc);
    end
    if (bus.out_valid && !busy) viol++;
    if (prev_done) busy_after = busy;
    if (done) begin
      done_cnt++;
      busy_at_done = busy;
    end
    prev_done = done;
  end

  task automatic clear_mon();
    got.delete();
    got_t.delete();
    done_cnt   = 0;
    busy_after = 1'b1;
  endtask

  task automatic do_start(input logic [7:0] se);
    StartEdge      = se;
    in_store_start = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_store_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_stop(input logic [3:0] m, input logic [9:0] crs);
    Coarse        = crs;
    in_store_stop = in_store_stop | m;
    repeat (5) @(posedge clk);
    #1 in_store_stop = in_store_stop & ~m;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk(tag, 64'(done_cnt), 64'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic check_words(input string tag, input int n, input logic [DW-1:0] e [4]);
    chk({tag, "_count"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(got[i]), 64'(e[i]));
  endtask

  logic [DW-1:0] e [4];
  int            t_start;

  initial begin
    irst           = 1'b1;
    in_store_start = 1'b0;
    in_store_stop  = '0;
    ch_en          = 4'b1111;
    StartEdge      = '0;
    FallEdge       = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    Coarse         = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 irst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset state
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out", 64'(bus.out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // Start with empty mask is ignored
    ch_en = 4'b0000;
    do_start(8'h11);
    chk("start_no_mask_busy", 64'(busy), 64'd0);
    ch_en = 4'b1111;

    // S1: stops 2,0,(2 again ignored),3,1; contiguous readout
    clear_mon();
    do_start(8'h5A);
    chk("armed_busy", 64'(busy), 64'd1);
    pulse_stop(4'b0100, 10'h102);
    pulse_stop(4'b0001, 10'h100);
    pulse_stop(4'b0100, 10'h3FF);
    pulse_stop(4'b1000, 10'h103);
    pulse_stop(4'b0010, 10'h101);
    wait_done("s1_done", 60);
    for (int k = 0; k < 4; k++) e[k] = mk(k, 1'b0, 10'(10'h100 + k), 8'h5A, 8'(8'hA0 + 8'h11 * k));
    check_words("s1", 4, e);
    if (got_t.size() == 4) chk("s1_contiguous", 64'(got_t[3] - got_t[0]), 64'd3);
    else chk("s1_contiguous_count", 64'(got_t.size()), 64'd4);
    chk("s1_busy_at_done", 64'(busy_at_done), 64'd1);
    chk("s1_busy_after_done", 64'(busy_after), 64'd0);

    // S2: ch0 and ch3 simultaneous
    clear_mon();
    do_start(8'h33);
    pulse_stop(4'b1001, 10'h2AA);
    pulse_stop(4'b0010, 10'h011);
    pulse_stop(4'b0100, 10'h022);
    wait_done("s2_done", 60);
    e[0] = mk(0, 1'b0, 10'h2AA, 8'h33, 8'hA0);
    e[1] = mk(1, 1'b0, 10'h011, 8'h33, 8'hB1);
    e[2] = mk(2, 1'b0, 10'h022, 8'h33, 8'hC2);
    e[3] = mk(3, 1'b0, 10'h2AA, 8'h33, 8'hD3);
    check_words("s2", 4, e);

    // S3: backpressure for 5 cycles on word 1
    clear_mon();
    bus.out_ready = 1'b0;
    do_start(8'hC7);
    pulse_stop(4'b1111, 10'h0F0);
    wait_valid("s3_valid", 40);
    for (int k = 0; k < 4; k++) e[k] = mk(k, 1'b0, 10'h0F0, 8'hC7, 8'(8'hA0 + 8'h11 * k));
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("s3_hold_valid%0d", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("s3_hold_word%0d", i), 64'(bus.out), 64'(e[1]));
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_done("s3_done", 30);
    check_words("s3", 4, e);

    // S4: mask 0101, stray stops before start are ignored
    clear_mon();
    pulse_stop(4'b1111, 10'h3FF);
    chk("s4_pre_start_busy", 64'(busy), 64'd0);
    ch_en = 4'b0101;
    do_start(8'h99);
    ch_en = 4'b1111;
    pulse_stop(4'b1111, 10'h155);
    wait_done("s4_done", 60);
    e[0] = mk(0, 1'b0, 10'h155, 8'h99, 8'hA0);
    e[1] = mk(2, 1'b0, 10'h155, 8'h99, 8'hC2);
    check_words("s4", 2, e);

    // S5: reset mid-readout after word 0
    clear_mon();
    bus.out_ready = 1'b0;
    do_start(8'h42);
    pulse_stop(4'b1111, 10'h077);
    wait_valid("s5_valid", 40);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    @(posedge clk); #1 irst = 1'b1;
    #1;
    chk("s5_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("s5_rst_out", 64'(bus.out), 64'd0);
    repeat (2) @(posedge clk);
    #1 irst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("s5_no_done", 64'(done_cnt), 64'd0);
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_words_before_rst", 64'(got.size()), 64'd1);
    bus.out_ready = 1'b1;
    clear_mon();
    do_start(8'h24);
    pulse_stop(4'b1111, 10'h0C3);
    wait_done("s5b_done", 60);
    for (int k = 0; k < 4; k++) e[k] = mk(k, 1'b0, 10'h0C3, 8'h24, 8'(8'hA0 + 8'h11 * k));
    check_words("s5b", 4, e);

`ifdef TDC_TIMEOUT_EN
    // Timeout with only ch1 hit
    clear_mon();
    t_start = cyc;
    do_start(8'h6E);
    pulse_stop(4'b0010, 10'h0AB);
    wait_done("tmo_done", 80);
    e[0] = mk(1, 1'b1, 10'h0AB, 8'h6E, 8'hB1);
    check_words("tmo", 1, e);
    if (got_t.size() > 0)
      chk("tmo_latency_ok", 64'((got_t[0] - t_start >= 18) && (got_t[0] - t_start <= 32)), 64'd1);
    // Timeout with no hits: done only
    clear_mon();
    do_start(8'h01);
    wait_done("tmo_empty_done", 80);
    chk("tmo_empty_words", 64'(got.size()), 64'd0);
`endif

    chk("valid_outside_busy", 64'(viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
